// File: rtl/pixel_path_sequencer.sv
// pixel_path_sequencer
//
// Frame-level pixel router. Each frame's pixels go to the external grayscale
// core, the sobel core, the gray core chained into the sobel core, or a
// fixed-depth bypass delay line. The mode is captured at frame start and held
// for the whole frame. Input and output pixels are counted. After the last
// input pixel the block drains the pipeline, waiting a bounded number of idle
// cycles for the remaining results. It then pulses frame_done_o and returns
// to idle.
//
// Ports
//   clk_i, nreset_i              clock, asynchronous active-low reset
//   mode_i                       00 gray->sobel, 01 sobel, 10 gray, 11 bypass
//   start_i                      frame start pulse, honoured only when idle
//   px_rdy_i, in_pixel_i         input pixel stream
//   gray_px_rdy_o, gray_px_o     pixel stream to the gray core
//   gray_px_i, gray_rdy_i        gray core results
//   sobel_start_o                one-cycle start pulse to the sobel core
//   sobel_px_rdy_o, sobel_px_o   pixel stream to the sobel core
//   sobel_px_i, sobel_rdy_i      sobel core results
//   out_pixel_o, px_rdy_o        registered output stream
//   mode_o                       latched frame mode
//   busy_o                       frame in progress (run or drain)
//   frame_done_o                 one-cycle end-of-frame pulse
//   err_o                        sticky error, cleared by the next start

module pixel_path_sequencer #(
  parameter int unsigned PX_IN_W      = 24,
  parameter int unsigned PX_OUT_W     = 8,
  parameter int unsigned FRAME_PIXELS = 4096,
  parameter int unsigned BYPASS_LAT   = 2,
  parameter int unsigned DRAIN_TMO    = 64
) (
  input  logic                clk_i,
  input  logic                nreset_i,
  input  logic [1:0]          mode_i,
  input  logic                start_i,
  input  logic                px_rdy_i,
  input  logic [PX_IN_W-1:0]  in_pixel_i,
  output logic                gray_px_rdy_o,
  output logic [PX_IN_W-1:0]  gray_px_o,
  input  logic [PX_OUT_W-1:0] gray_px_i,
  input  logic                gray_rdy_i,
  output logic                sobel_start_o,
  output logic                sobel_px_rdy_o,
  output logic [PX_OUT_W-1:0] sobel_px_o,
  input  logic [PX_OUT_W-1:0] sobel_px_i,
  input  logic                sobel_rdy_i,
  output logic [PX_IN_W-1:0]  out_pixel_o,
  output logic                px_rdy_o,
  output logic [1:0]          mode_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                err_o
);

  localparam int unsigned CntW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned TmoW = $clog2(DRAIN_TMO + 1);

  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_PIXELS - 1);
  localparam logic [CntW-1:0] FrameFull = CntW'(FRAME_PIXELS);
  localparam logic [TmoW-1:0] TmoLimit  = TmoW'(DRAIN_TMO);

  localparam logic [1:0] ModeGraySobel = 2'b00;
  localparam logic [1:0] ModeSobel     = 2'b01;
  localparam logic [1:0] ModeGray      = 2'b10;
  localparam logic [1:0] ModeBypass    = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e               state_q;
  logic [1:0]           mode_q;
  logic [CntW-1:0]      in_cnt_q;
  logic [CntW-1:0]      out_cnt_q;
  logic [TmoW-1:0]      tmo_cnt_q;
  logic                 err_q;
  logic                 sobel_start_q;
  logic                 px_rdy_q;
  logic [PX_IN_W-1:0]   out_pixel_q;
  logic [BYPASS_LAT-1:0] dl_vld_q;
  logic [PX_IN_W-1:0]   dl_px_q [BYPASS_LAT];

  logic               run;
  logic               busy;
  logic               dl_in_vld;
  logic               src_vld;
  logic [PX_IN_W-1:0] src_px;

  // Input forwarding and output source selection, both keyed by the latched mode.
  always_comb begin
    run            = (state_q == StRun);
    busy           = run || (state_q == StDrain);
    gray_px_o      = in_pixel_i;
    gray_px_rdy_o  = 1'b0;
    sobel_px_rdy_o = 1'b0;
    sobel_px_o     = in_pixel_i[PX_OUT_W-1:0];
    dl_in_vld      = 1'b0;
    src_vld        = 1'b0;
    src_px         = '0;
    unique case (mode_q)
      ModeGraySobel: begin
        gray_px_rdy_o  = run & px_rdy_i;
        // Gray results keep feeding sobel during drain so the frame tail completes.
        sobel_px_rdy_o = busy & gray_rdy_i;
        sobel_px_o     = gray_px_i;
        src_vld        = sobel_rdy_i;
        src_px         = PX_IN_W'(sobel_px_i);
      end
      ModeSobel: begin
        sobel_px_rdy_o = run & px_rdy_i;
        src_vld        = sobel_rdy_i;
        src_px         = PX_IN_W'(sobel_px_i);
      end
      ModeGray: begin
        gray_px_rdy_o = run & px_rdy_i;
        src_vld       = gray_rdy_i;
        src_px        = PX_IN_W'(gray_px_i);
      end
      ModeBypass: begin
        dl_in_vld = run & px_rdy_i;
        src_vld   = dl_vld_q[BYPASS_LAT-1];
        src_px    = dl_px_q[BYPASS_LAT-1];
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= StIdle;
      mode_q        <= 2'b00;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      err_q         <= 1'b0;
      sobel_start_q <= 1'b0;
      px_rdy_q      <= 1'b0;
      out_pixel_q   <= '0;
      dl_vld_q      <= '0;
      for (int unsigned i = 0; i < BYPASS_LAT; i++) begin
        dl_px_q[i] <= '0;
      end
    end else begin
      sobel_start_q <= 1'b0;

      // Output register: results only pass while a frame is active.
      px_rdy_q <= busy & src_vld;
      if (busy && src_vld) begin
        out_pixel_q <= src_px;
        if (out_cnt_q != FrameFull) begin
          out_cnt_q <= out_cnt_q + 1'b1;
        end
      end

      // Bypass delay line shifts every cycle; only run-state pixels enter it.
      dl_vld_q[0] <= dl_in_vld;
      dl_px_q[0]  <= in_pixel_i;
      for (int unsigned i = 1; i < BYPASS_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_px_q[i]  <= dl_px_q[i-1];
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            mode_q        <= mode_i;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            err_q         <= 1'b0;
            sobel_start_q <= ~mode_i[1];
            dl_vld_q      <= '0;
            state_q       <= StRun;
          end else if (src_vld && out_cnt_q == FrameFull) begin
            // Result after a complete frame: the source produced too many.
            err_q <= 1'b1;
          end
        end
        StRun: begin
          if (px_rdy_i) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == FrameLast) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (px_rdy_i) begin
            err_q <= 1'b1;
          end
          if (src_vld) begin
            tmo_cnt_q <= '0;
          end else if (tmo_cnt_q != TmoLimit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
          // A full frame takes priority over a coincident timeout.
          if (out_cnt_q == FrameFull) begin
            state_q <= StDone;
          end else if (tmo_cnt_q == TmoLimit) begin
            state_q <= StDone;
            err_q   <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (src_vld && out_cnt_q == FrameFull) begin
            err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sobel_start_o = sobel_start_q;
  assign out_pixel_o   = out_pixel_q;
  assign px_rdy_o      = px_rdy_q;
  assign mode_o        = mode_q;
  assign busy_o        = (state_q == StRun) || (state_q == StDrain);
  assign frame_done_o  = (state_q == StDone);
  assign err_o         = err_q;

endmodule

// File: tb/tb_pixel_path_sequencer.sv
// Testbench for pixel_path_sequencer: external gray/sobel cores are modelled as
// 3-cycle pipelines; expected outputs (value and arrival edge) come from a
// per-mode transfer function and latency, checked by an output monitor.

module tb_pixel_path_sequencer;

  localparam int unsigned FP  = 16;
  localparam int unsigned BL  = 2;
  localparam int unsigned TMO = 8;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic [1:0]  mode_i;
  logic        start_i;
  logic        px_rdy_i;
  logic [23:0] in_pixel_i;
  logic        gray_px_rdy_o;
  logic [23:0] gray_px_o;
  logic [7:0]  gray_px_i;
  logic        gray_rdy_i;
  logic        sobel_start_o;
  logic        sobel_px_rdy_o;
  logic [7:0]  sobel_px_o;
  logic [7:0]  sobel_px_i;
  logic        sobel_rdy_i;
  logic [23:0] out_pixel_o;
  logic        px_rdy_o;
  logic [1:0]  mode_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  pixel_path_sequencer #(
    .PX_IN_W(24), .PX_OUT_W(8), .FRAME_PIXELS(FP), .BYPASS_LAT(BL), .DRAIN_TMO(TMO)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .mode_i(mode_i), .start_i(start_i),
    .px_rdy_i(px_rdy_i), .in_pixel_i(in_pixel_i),
    .gray_px_rdy_o(gray_px_rdy_o), .gray_px_o(gray_px_o),
    .gray_px_i(gray_px_i), .gray_rdy_i(gray_rdy_i),
    .sobel_start_o(sobel_start_o), .sobel_px_rdy_o(sobel_px_rdy_o),
    .sobel_px_o(sobel_px_o), .sobel_px_i(sobel_px_i), .sobel_rdy_i(sobel_rdy_i),
    .out_pixel_o(out_pixel_o), .px_rdy_o(px_rdy_o), .mode_o(mode_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray_fn(input logic [23:0] p);
    return p[7:0] ^ p[15:8] ^ p[23:16];
  endfunction

  function automatic logic [7:0] sobel_fn(input logic [7:0] v);
    return (v << 1) + v + 8'd1;
  endfunction

  function automatic logic [23:0] ref_out(input logic [1:0] m, input logic [23:0] p);
    case (m)
      2'b00:   return {16'h0, sobel_fn(gray_fn(p))};
      2'b01:   return {16'h0, sobel_fn(p[7:0])};
      2'b10:   return {16'h0, gray_fn(p)};
      default: return p;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [1:0] m);
    case (m)
      2'b00:   return 6;
      2'b11:   return BL;
      default: return 3;
    endcase
  endfunction

  // External core models, 3-cycle latency each.
  logic       gray_inject = 1'b0;
  logic       sobel_block = 1'b0;
  logic [2:0] g_vld, s_vld;
  logic [7:0] g_dat [3];
  logic [7:0] s_dat [3];

  always @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      g_vld <= '0;
      s_vld <= '0;
      for (int i = 0; i < 3; i++) begin
        g_dat[i] <= '0;
        s_dat[i] <= '0;
      end
    end else begin
      g_vld    <= {g_vld[1:0], gray_px_rdy_o};
      g_dat[0] <= gray_fn(gray_px_o);
      g_dat[1] <= g_dat[0];
      g_dat[2] <= g_dat[1];
      s_vld    <= {s_vld[1:0], sobel_px_rdy_o & ~sobel_block};
      s_dat[0] <= sobel_fn(sobel_px_o);
      s_dat[1] <= s_dat[0];
      s_dat[2] <= s_dat[1];
    end
  end

  assign gray_rdy_i  = g_vld[2] | gray_inject;
  assign gray_px_i   = g_dat[2];
  assign sobel_rdy_i = s_vld[2];
  assign sobel_px_i  = s_dat[2];

  // Scoreboard of expected outputs: value and the clock edge after which it shows.
  typedef struct {
    int unsigned at;
    logic [23:0] px;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned edge_n = 0;
  int unsigned done_cnt = 0;
  int unsigned done_edge = 0;
  int unsigned last_out_edge = 0;

  always begin
    @(posedge clk_i);
    edge_n++;
    #1;
    if (frame_done_o) begin
      done_cnt++;
      done_edge = edge_n;
    end
    if (exp_q.size() != 0 && exp_q[0].at == edge_n) begin
      check_eq("out_vld", 32'(px_rdy_o), 32'd1);
      check_eq("out_px", 32'(out_pixel_o), 32'(exp_q[0].px));
      void'(exp_q.pop_front());
    end else if (px_rdy_o) begin
      check_eq("out_extra", 32'(px_rdy_o), 32'd0);
    end
    if (px_rdy_o) last_out_edge = edge_n;
  end

  task automatic do_frame(input logic [1:0] mode, input bit seq_px, input int max_gap,
                          input bit alt_mode, input bit overrun, input bit block_last);
    int unsigned d0;
    logic [23:0] px;
    int          k;
    @(negedge clk_i);
    mode_i  = mode;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    mode_i  = alt_mode ? ~mode : 2'($urandom);
    check_eq("sobel_start", 32'(sobel_start_o), 32'(mode == 2'b00 || mode == 2'b01));
    check_eq("busy_run", 32'(busy_o), 32'd1);
    check_eq("mode_latch", 32'(mode_o), 32'(mode));
    check_eq("err_clr", 32'(err_o), 32'd0);
    d0 = done_cnt;
    for (int i = 0; i < int'(FP); i++) begin
      k = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (k) begin
        px_rdy_i   = 1'b0;
        in_pixel_i = 24'($urandom);
        @(negedge clk_i);
      end
      px = seq_px ? 24'(i + 1) : 24'($urandom);
      px_rdy_i   = 1'b1;
      in_pixel_i = px;
      if (block_last && i == int'(FP) - 1) begin
        sobel_block = 1'b1;
      end else begin
        exp_q.push_back('{at: edge_n + 1 + ref_lat(mode), px: ref_out(mode, px)});
      end
      #1;
      check_eq("fwd_gray", 32'(gray_px_rdy_o), 32'(mode == 2'b00 || mode == 2'b10));
      if (mode != 2'b00) check_eq("fwd_sobel", 32'(sobel_px_rdy_o), 32'(mode == 2'b01));
      if (mode == 2'b01) check_eq("sobel_px", 32'(sobel_px_o), 32'(px[7:0]));
      check_eq("gray_px", 32'(gray_px_o), 32'(px));
      check_eq("mode_hold", 32'(mode_o), 32'(mode));
      if (i == 1) check_eq("sobel_start_pulse", 32'(sobel_start_o), 32'd0);
      @(negedge clk_i);
    end
    px_rdy_i = 1'b0;
    if (overrun) begin
      px_rdy_i   = 1'b1;
      in_pixel_i = 24'($urandom);
      #1;
      check_eq("ovr_gray", 32'(gray_px_rdy_o), 32'd0);
      if (mode != 2'b00) check_eq("ovr_sobel", 32'(sobel_px_rdy_o), 32'd0);
      @(negedge clk_i);
      px_rdy_i = 1'b0;
    end
    for (int c = 0; c < 200 && done_cnt == d0; c++) @(negedge clk_i);
    check_eq("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (3) @(negedge clk_i);
    check_eq("done_once", done_cnt - d0, 32'd1);
    check_eq("err_end", 32'(err_o), 32'(overrun | block_last));
    check_eq("busy_idle", 32'(busy_o), 32'd0);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    sobel_block = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset_i   = 1'b0;
    mode_i     = 2'b00;
    start_i    = 1'b0;
    px_rdy_i   = 1'b0;
    in_pixel_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_px_rdy", 32'(px_rdy_o), 32'd0);
    check_eq("rst_out_px", 32'(out_pixel_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(frame_done_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_mode", 32'(mode_o), 32'd0);
    check_eq("rst_sobel_start", 32'(sobel_start_o), 32'd0);
    nreset_i = 1'b1;
    @(negedge clk_i);

    // Pixels presented in idle are not forwarded.
    px_rdy_i   = 1'b1;
    in_pixel_i = 24'h123456;
    #1;
    check_eq("idle_gray", 32'(gray_px_rdy_o), 32'd0);
    check_eq("idle_sobel", 32'(sobel_px_rdy_o), 32'd0);
    @(negedge clk_i);
    px_rdy_i = 1'b0;

    do_frame(2'b11, 1'b1, 0, 1'b0, 1'b0, 1'b0);   // bypass, sequential pixels
    do_frame(2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // gray -> sobel chain
    do_frame(2'b10, 1'b0, 2, 1'b1, 1'b0, 1'b0);   // mode_i changed mid-frame
    for (int f = 0; f < 4; f++) begin
      do_frame(2'($urandom_range(3, 0)), 1'b0, 3, 1'b0, 1'b0, 1'b0);
    end

    // Stray gray result after a complete frame flags an error.
    do_frame(2'b10, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    gray_inject = 1'b1;
    @(negedge clk_i);
    gray_inject = 1'b0;
    @(negedge clk_i);
    check_eq("stray_err", 32'(err_o), 32'd1);

    // Missing sobel result: drain timeout.
    do_frame(2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_eq("tmo_window", 32'((done_edge - last_out_edge >= TMO) &&
                                (done_edge - last_out_edge <= TMO + 2)), 32'd1);

    // Overrun pixel after the last one.
    do_frame(2'b11, 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a bypass frame.
    @(negedge clk_i);
    mode_i  = 2'b11;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      px_rdy_i   = 1'b1;
      in_pixel_i = 24'($urandom);
      exp_q.push_back('{at: edge_n + 1 + ref_lat(2'b11), px: in_pixel_i});
      @(negedge clk_i);
    end
    nreset_i = 1'b0;
    exp_q.delete();
    #1;
    check_eq("mid_rst_px_rdy", 32'(px_rdy_o), 32'd0);
    check_eq("mid_rst_out_px", 32'(out_pixel_o), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
    check_eq("mid_rst_mode", 32'(mode_o), 32'd0);
    check_eq("mid_rst_gray_rdy", 32'(gray_px_rdy_o), 32'd0);
    check_eq("mid_rst_sobel_rdy", 32'(sobel_px_rdy_o), 32'd0);
    px_rdy_i = 1'b0;
    repeat (2) @(negedge clk_i);
    nreset_i = 1'b1;
    do_frame(2'b11, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
